// File: rtl/stall_flush_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall unit: register-index width,
// the x0 constant, FSM state encoding and the load-use hazard predicate.
package stall_flush_unit_pkg;

   localparam int REG_IDX_W = 5;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   localparam reg_idx_t REG_X0 = 5'd0;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FAULT    = 2'd2
   } sfu_state_e;

   // A load whose destination feeds the Decode instruction cannot be forwarded in time.
   function automatic logic load_use_hazard(input logic     is_load,
                                            input reg_idx_t rd,
                                            input reg_idx_t rs1,
                                            input reg_idx_t rs2);
      return is_load && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/stall_flush_unit_if.sv
// Hazard-side signal bundle between the pipeline datapath (master) and the
// stall/flush unit (slave).
interface stall_flush_unit_if #(
   parameter int CNT_W = 32
);
   import stall_flush_unit_pkg::*;

   reg_idx_t         Rs1D;
   reg_idx_t         Rs2D;
   reg_idx_t         RdE;
   logic             ResultSrcE0;
   logic             PCSrcE;
   logic             DMemReqM;
   logic             DMemReadyM;
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             StallM;
   logic             FlushD;
   logic             FlushE;
   logic             FlushW;
   logic             MemFault;
   logic [CNT_W-1:0] StallCycles;
   logic [CNT_W-1:0] FlushEvents;

   modport master (
      output Rs1D, Rs2D, RdE, ResultSrcE0, PCSrcE, DMemReqM, DMemReadyM,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault,
             StallCycles, FlushEvents
   );

   modport slave (
      input  Rs1D, Rs2D, RdE, ResultSrcE0, PCSrcE, DMemReqM, DMemReadyM,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault,
             StallCycles, FlushEvents
   );

endinterface

// File: rtl/stall_flush_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clears on rst.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/stall_flush_unit.sv
// Stall/flush control for the 5-stage pipeline: load-use stalls, taken-branch
// flushes and data-memory wait handling with a sticky timeout fault.
module stall_flush_unit
   import stall_flush_unit_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input logic               clk,
   input logic               rst,
   stall_flush_unit_if.slave sfu
);

   localparam int TMR_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MEM_TIMEOUT);

   sfu_state_e       state_q;
   sfu_state_e       state_d;
   logic [TMR_W-1:0] timer_q;
   logic [TMR_W-1:0] timer_d;
   logic             mem_fault_q;
   logic             mem_fault_d;

   logic             mem_stall;
   logic             lw_stall;
   logic             stall_inc;
   logic             flush_inc;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      mem_fault_d = mem_fault_q;
      case (state_q)
         ST_RUN: begin
            if (sfu.DMemReqM && !sfu.DMemReadyM) begin
               state_d = ST_MEM_WAIT;
               timer_d = TMR_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            // Ready takes precedence over a timeout landing in the same cycle.
            if (sfu.DMemReadyM) begin
               state_d = ST_RUN;
               timer_d = '0;
            end else if ((MEM_TIMEOUT != 0) && (timer_q == TMR_LIMIT)) begin
               state_d     = ST_FAULT;
               mem_fault_d = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_FAULT: begin
            mem_fault_d = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         timer_q     <= '0;
         mem_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         mem_fault_q <= mem_fault_d;
      end
   end

   always_comb begin
      mem_stall = 1'b0;
      case (state_q)
         ST_RUN:      mem_stall = sfu.DMemReqM && !sfu.DMemReadyM;
         ST_MEM_WAIT: mem_stall = !sfu.DMemReadyM;
         ST_FAULT:    mem_stall = 1'b1;
         default:     mem_stall = 1'b0;
      endcase
   end

   assign lw_stall = load_use_hazard(sfu.ResultSrcE0, sfu.RdE, sfu.Rs1D, sfu.Rs2D);

   // A memory stall freezes E, so a pending branch is simply re-presented later.
   always_comb begin
      sfu.StallF = 1'b0;
      sfu.StallD = 1'b0;
      sfu.StallE = 1'b0;
      sfu.StallM = 1'b0;
      sfu.FlushD = 1'b0;
      sfu.FlushE = 1'b0;
      sfu.FlushW = 1'b0;
      if (rst) begin
         sfu.FlushD = 1'b1;
         sfu.FlushE = 1'b1;
         sfu.FlushW = 1'b1;
      end else if (mem_stall) begin
         sfu.StallF = 1'b1;
         sfu.StallD = 1'b1;
         sfu.StallE = 1'b1;
         sfu.StallM = 1'b1;
         sfu.FlushW = 1'b1;
      end else begin
         sfu.StallF = lw_stall;
         sfu.StallD = lw_stall;
         sfu.FlushD = sfu.PCSrcE;
         sfu.FlushE = lw_stall || sfu.PCSrcE;
      end
   end

   assign sfu.MemFault = mem_fault_q;

   assign stall_inc = !rst && (mem_stall || lw_stall);
   assign flush_inc = !rst && sfu.PCSrcE && !mem_stall;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (sfu.StallCycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (sfu.FlushEvents)
   );

endmodule

// File: tb/tb_stall_flush_unit.sv
// Directed scoreboard bench for stall_flush_unit with a short timeout and
// narrow counters so fault and saturation behaviour are reachable quickly.
module tb_stall_flush_unit;

   localparam int TB_TIMEOUT = 4;
   localparam int TB_CNT_W   = 3;

   // Output vector order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemFault}
   localparam logic [7:0] O_RST  = 8'b0000_1110;
   localparam logic [7:0] O_RSTF = 8'b0000_1111;
   localparam logic [7:0] O_IDLE = 8'b0000_0000;
   localparam logic [7:0] O_LW   = 8'b1100_0100;
   localparam logic [7:0] O_BR   = 8'b0000_1100;
   localparam logic [7:0] O_LWBR = 8'b1100_1100;
   localparam logic [7:0] O_MEM  = 8'b1111_0010;
   localparam logic [7:0] O_FLT  = 8'b1111_0011;

   typedef struct {
      string                tag;
      logic [7:0]           outs;
      logic [TB_CNT_W-1:0]  sc;
      logic [TB_CNT_W-1:0]  fe;
   } exp_t;

   logic clk;
   logic rst;

   stall_flush_unit_if #(.CNT_W(TB_CNT_W)) sfu_if ();

   stall_flush_unit #(
      .MEM_TIMEOUT (TB_TIMEOUT),
      .CNT_W       (TB_CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sfu (sfu_if.slave)
   );

   exp_t                sb[$];
   int                  checks   = 0;
   int                  failures = 0;
   logic [TB_CNT_W-1:0] exp_sc   = '0;
   logic [TB_CNT_W-1:0] exp_fe   = '0;
   localparam logic [TB_CNT_W-1:0] CNT_MAX = {TB_CNT_W{1'b1}};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One pipeline cycle: drive inputs, queue the expectation, compare mid-cycle,
   // then advance the reference counters according to the expected outputs.
   task automatic step(input string      tag,
                       input logic       r,
                       input logic [4:0] rs1,
                       input logic [4:0] rs2,
                       input logic [4:0] rd,
                       input logic       ld,
                       input logic       pc,
                       input logic       req,
                       input logic       rdy,
                       input logic [7:0] exp_o);
      exp_t e;
      exp_t got_e;
      logic [7:0] obs;
      rst                    = r;
      sfu_if.Rs1D            = rs1;
      sfu_if.Rs2D            = rs2;
      sfu_if.RdE             = rd;
      sfu_if.ResultSrcE0     = ld;
      sfu_if.PCSrcE          = pc;
      sfu_if.DMemReqM        = req;
      sfu_if.DMemReadyM      = rdy;
      e.tag  = tag;
      e.outs = exp_o;
      e.sc   = exp_sc;
      e.fe   = exp_fe;
      sb.push_back(e);
      @(negedge clk);
      got_e = sb.pop_front();
      obs = {sfu_if.StallF, sfu_if.StallD, sfu_if.StallE, sfu_if.StallM,
             sfu_if.FlushD, sfu_if.FlushE, sfu_if.FlushW, sfu_if.MemFault};
      checks++;
      assert (obs === got_e.outs) else begin
         failures++;
         $error("FAIL %s outputs observed=%b expected=%b", got_e.tag, obs, got_e.outs);
      end
      checks++;
      assert (sfu_if.StallCycles === got_e.sc) else begin
         failures++;
         $error("FAIL %s StallCycles observed=%0d expected=%0d", got_e.tag, sfu_if.StallCycles, got_e.sc);
      end
      checks++;
      assert (sfu_if.FlushEvents === got_e.fe) else begin
         failures++;
         $error("FAIL %s FlushEvents observed=%0d expected=%0d", got_e.tag, sfu_if.FlushEvents, got_e.fe);
      end
      if (r) begin
         exp_sc = '0;
         exp_fe = '0;
      end else begin
         if ((exp_o[7] || exp_o[4]) && exp_sc != CNT_MAX) exp_sc = exp_sc + 1'b1;
         if (exp_o[3] && exp_fe != CNT_MAX) exp_fe = exp_fe + 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      sfu_if.Rs1D = '0; sfu_if.Rs2D = '0; sfu_if.RdE = '0;
      sfu_if.ResultSrcE0 = 1'b0; sfu_if.PCSrcE = 1'b0;
      sfu_if.DMemReqM = 1'b0; sfu_if.DMemReadyM = 1'b0;

      //   tag           rst rs1 rs2 rd  ld pc req rdy expected
      step("reset0",     1, 0,  0,  0,  0, 0, 0,  0,  O_RST);
      step("reset1",     1, 0,  0,  0,  0, 0, 0,  0,  O_RST);
      step("idle",       0, 0,  0,  0,  0, 0, 0,  0,  O_IDLE);
      step("lw_rs1",     0, 5,  1,  5,  1, 0, 0,  0,  O_LW);
      step("idle_cnt1",  0, 0,  0,  0,  0, 0, 0,  0,  O_IDLE);
      step("x0_load",    0, 3,  0,  0,  1, 0, 0,  0,  O_IDLE);
      step("nonload",    0, 7,  2,  7,  0, 0, 0,  0,  O_IDLE);
      step("lw_rs2",     0, 1,  9,  9,  1, 0, 0,  0,  O_LW);
      step("branch",     0, 0,  0,  0,  0, 1, 0,  0,  O_BR);
      step("branch_lw",  0, 4,  0,  4,  1, 1, 0,  0,  O_LWBR);
      step("idle_cnt2",  0, 0,  0,  0,  0, 0, 0,  0,  O_IDLE);

      // Memory wait with a taken branch and load-use held in the background.
      step("mw_req",     0, 0,  0,  0,  0, 1, 1,  0,  O_MEM);
      step("mw_wait1",   0, 6,  0,  6,  1, 1, 1,  0,  O_MEM);
      step("mw_wait2",   0, 0,  0,  0,  0, 1, 1,  0,  O_MEM);
      step("mw_ready",   0, 0,  0,  0,  0, 1, 1,  1,  O_BR);
      step("mw_after",   0, 0,  0,  0,  0, 0, 0,  0,  O_IDLE);

      // Timeout into FAULT; the stall counter saturates along the way.
      step("to_reset",   1, 0,  0,  0,  0, 0, 0,  0,  O_RST);
      step("to_req",     0, 0,  0,  0,  0, 0, 1,  0,  O_MEM);
      step("to_t1",      0, 0,  0,  0,  0, 0, 1,  0,  O_MEM);
      step("to_t2",      0, 0,  0,  0,  0, 0, 1,  0,  O_MEM);
      step("to_t3",      0, 0,  0,  0,  0, 0, 1,  0,  O_MEM);
      step("to_t4",      0, 0,  0,  0,  0, 1, 1,  0,  O_MEM);
      step("fault",      0, 0,  0,  0,  0, 1, 0,  0,  O_FLT);
      step("fault_rdy",  0, 0,  0,  0,  0, 0, 1,  1,  O_FLT);
      step("fault_rst",  1, 0,  0,  0,  0, 0, 0,  0,  O_RSTF);
      step("post_fault", 0, 0,  0,  0,  0, 0, 0,  0,  O_IDLE);

      // Ready arrives exactly when the timer hits the limit.
      step("rt_req",     0, 0,  0,  0,  0, 0, 1,  0,  O_MEM);
      step("rt_t1",      0, 0,  0,  0,  0, 0, 1,  0,  O_MEM);
      step("rt_t2",      0, 0,  0,  0,  0, 0, 1,  0,  O_MEM);
      step("rt_t3",      0, 0,  0,  0,  0, 0, 1,  0,  O_MEM);
      step("rt_ready",   0, 0,  0,  0,  0, 0, 1,  1,  O_IDLE);
      step("rt_after",   0, 0,  0,  0,  0, 0, 0,  0,  O_IDLE);

      // Ten load-use cycles saturate the 3-bit stall counter at 7.
      step("sat_reset",  1, 0,  0,  0,  0, 0, 0,  0,  O_RST);
      for (int i = 0; i < 10; i++) begin
         step("sat_lw",  0, 12, 3,  12, 1, 0, 0,  0,  O_LW);
      end
      step("sat_check",  0, 0,  0,  0,  0, 0, 0,  0,  O_IDLE);

      // Reset while waiting on memory returns to RUN.
      step("rw_req",     0, 0,  0,  0,  0, 0, 1,  0,  O_MEM);
      step("rw_reset",   1, 8,  0,  8,  1, 1, 1,  0,  O_RST);
      step("rw_after",   0, 0,  0,  0,  0, 0, 0,  0,  O_IDLE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
